// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: opcodes, operand register
// addresses and the state encodings of the command FSM and TX sequencer.
package uart_sys_pkg;

    // Frame opcodes recognised in IDLE
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file locations the ALU reads its operands from
    localparam int REG_OP_A = 0;
    localparam int REG_OP_B = 1;

    // Command FSM; ST_TX_SEND covers the whole hand-off to the TX sequencer
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_SEND
    } cmd_state_e;

    // TX sequencer: send one byte, then hold until the UART finishes it
    typedef enum logic [1:0] {
        TXS_IDLE,
        TXS_SEND,
        TXS_HOLD
    } tx_state_e;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the UART RX/TX, register-file and ALU signals around the command
// controller. master = the controller, slave = the surrounding system.
interface uart_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) ();
    logic [DATA_WIDTH-1:0]   rx_p_data;
    logic                    rx_d_vld;
    logic                    rx_par_err;
    logic                    rx_stp_err;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_data_vld;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_out_vld;
    logic                    tx_busy;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic                    rf_wr_en;
    logic                    rf_rd_en;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic                    alu_en;
    logic [FUN_WIDTH-1:0]    alu_fun;
    logic                    clk_gate_en;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_d_vld;
    logic                    cmd_err;

    modport master (
        input  rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
        input  rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, tx_busy,
        output rf_addr, rf_wr_en, rf_rd_en, rf_wr_data,
        output alu_en, alu_fun, clk_gate_en, tx_p_data, tx_d_vld, cmd_err
    );

    modport slave (
        output rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
        output rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, tx_busy,
        input  rf_addr, rf_wr_en, rf_rd_en, rf_wr_data,
        input  alu_en, alu_fun, clk_gate_en, tx_p_data, tx_d_vld, cmd_err
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Serialises up to two response bytes (byte0 first) onto the UART TX
// valid/busy handshake and pulses done_o after the last byte has gone out.
module uart_tx_sequencer
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] byte0_i,
    input  logic [DATA_WIDTH-1:0] byte1_i,
    input  logic [1:0]            count_i,
    input  logic                  tx_busy_i,
    output logic [DATA_WIDTH-1:0] tx_p_data_o,
    output logic                  tx_d_vld_o,
    output logic                  done_o
);
    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] head_q;       // next byte to send
    logic [DATA_WIDTH-1:0] tail_q;       // byte queued behind it
    logic [1:0]            left_q;       // bytes not yet handed to the UART
    logic                  busy_seen_q;  // UART has acknowledged the current byte
    logic [DATA_WIDTH-1:0] tx_p_data_q;
    logic                  tx_d_vld_q;
    logic                  done_q;

    // Handshake FSM: pulse valid only while the UART is free, then wait for
    // a full busy 1->0 cycle before moving on.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and
        // clk must be running for it to take effect.
        if (!rst_n) begin
            state_q     <= TXS_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            left_q      <= '0;
            busy_seen_q <= 1'b0;
            tx_p_data_q <= '0;
            tx_d_vld_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tx_d_vld_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                TXS_IDLE: begin
                    if (start_i) begin
                        head_q  <= byte0_i;
                        tail_q  <= byte1_i;
                        left_q  <= count_i;
                        state_q <= TXS_SEND;
                    end
                end
                TXS_SEND: begin
                    if (!tx_busy_i) begin
                        tx_p_data_q <= head_q;
                        tx_d_vld_q  <= 1'b1;
                        head_q      <= tail_q;
                        left_q      <= left_q - 2'd1;
                        busy_seen_q <= 1'b0;
                        state_q     <= TXS_HOLD;
                    end
                end
                TXS_HOLD: begin
                    if (!busy_seen_q) begin
                        busy_seen_q <= tx_busy_i;
                    end else if (!tx_busy_i) begin
                        if (left_q == 2'd0) begin
                            done_q  <= 1'b1;
                            state_q <= TXS_IDLE;
                        end else begin
                            state_q <= TXS_SEND;
                        end
                    end
                end
                default: state_q <= TXS_IDLE;
            endcase
        end
    end

    assign tx_p_data_o = tx_p_data_q;
    assign tx_d_vld_o  = tx_d_vld_q;
    assign done_o      = done_q;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses UART RX frames into register-file writes/reads
// and ALU operations, gates the ALU clock, and returns results over UART TX.
module uart_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_cmd_ctrl_if.master bus
);
    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);

    cmd_state_e            state_q;
    logic [TO_W-1:0]       timeout_q;
    logic [ADDR_WIDTH-1:0] rf_addr_q;
    logic                  rf_wr_en_q;
    logic                  rf_rd_en_q;
    logic [DATA_WIDTH-1:0] rf_wr_data_q;
    logic                  alu_en_q;
    logic [FUN_WIDTH-1:0]  alu_fun_q;
    logic                  clk_gate_en_q;
    logic                  cmd_err_q;
    logic                  tx_start_q;
    logic [DATA_WIDTH-1:0] tx_byte0_q;
    logic [DATA_WIDTH-1:0] tx_byte1_q;
    logic [1:0]            tx_count_q;
    logic                  tx_done;

    logic rx_ok;
    logic rx_bad;
    logic in_frame;
    logic timed_out;

    assign rx_ok     = bus.rx_d_vld && !bus.rx_par_err && !bus.rx_stp_err;
    assign rx_bad    = bus.rx_d_vld && (bus.rx_par_err || bus.rx_stp_err);
    // Only states that are collecting frame bytes react to corrupted bytes;
    // waiting and transmitting states drop all RX traffic.
    assign in_frame  = state_q inside {ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                       ST_ALU_A, ST_ALU_B, ST_ALU_FUN};
    assign timed_out = (timeout_q == TO_W'(RSP_TIMEOUT - 1));

    // Command FSM with registered strobes; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timeout_q     <= '0;
            rf_addr_q     <= '0;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_byte0_q    <= '0;
            tx_byte1_q    <= '0;
            tx_count_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the state as it was at the clock edge, regardless of order.
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            tx_start_q <= 1'b0;
            if (rx_bad && in_frame) begin
                cmd_err_q <= 1'b1;
                state_q   <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_ok) begin
                            case (bus.rx_p_data)
                                DATA_WIDTH'(CMD_RF_WR):   state_q <= ST_WR_ADDR;
                                DATA_WIDTH'(CMD_RF_RD):   state_q <= ST_RD_ADDR;
                                DATA_WIDTH'(CMD_ALU_OP):  state_q <= ST_ALU_A;
                                DATA_WIDTH'(CMD_ALU_NOP): state_q <= ST_ALU_FUN;
                                default:                  cmd_err_q <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (rx_ok) begin
                            rf_addr_q <= bus.rx_p_data[ADDR_WIDTH-1:0];
                            state_q   <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (rx_ok) begin
                            rf_wr_data_q <= bus.rx_p_data;
                            rf_wr_en_q   <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (rx_ok) begin
                            rf_addr_q  <= bus.rx_p_data[ADDR_WIDTH-1:0];
                            rf_rd_en_q <= 1'b1;
                            timeout_q  <= '0;
                            state_q    <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (bus.rf_rd_data_vld) begin
                            tx_byte0_q <= bus.rf_rd_data;
                            tx_count_q <= 2'd1;
                            tx_start_q <= 1'b1;
                            state_q    <= ST_TX_SEND;
                        end else if (timed_out) begin
                            cmd_err_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            timeout_q <= timeout_q + TO_W'(1);
                        end
                    end
                    ST_ALU_A, ST_ALU_B: begin
                        if (rx_ok) begin
                            rf_addr_q    <= (state_q == ST_ALU_A) ? ADDR_WIDTH'(REG_OP_A)
                                                                  : ADDR_WIDTH'(REG_OP_B);
                            rf_wr_data_q <= bus.rx_p_data;
                            rf_wr_en_q   <= 1'b1;
                            state_q      <= (state_q == ST_ALU_A) ? ST_ALU_B : ST_ALU_FUN;
                        end
                    end
                    ST_ALU_FUN: begin
                        if (rx_ok) begin
                            alu_fun_q     <= bus.rx_p_data[FUN_WIDTH-1:0];
                            clk_gate_en_q <= 1'b1;
                            alu_en_q      <= 1'b1;
                            timeout_q     <= '0;
                            state_q       <= ST_ALU_WAIT;
                        end
                    end
                    ST_ALU_WAIT: begin
                        if (bus.alu_out_vld) begin
                            tx_byte0_q    <= bus.alu_out[DATA_WIDTH-1:0];
                            tx_byte1_q    <= bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                            tx_count_q    <= 2'd2;
                            tx_start_q    <= 1'b1;
                            alu_en_q      <= 1'b0;
                            clk_gate_en_q <= 1'b0;
                            state_q       <= ST_TX_SEND;
                        end else if (timed_out) begin
                            cmd_err_q     <= 1'b1;
                            alu_en_q      <= 1'b0;
                            clk_gate_en_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end else begin
                            timeout_q <= timeout_q + TO_W'(1);
                        end
                    end
                    ST_TX_SEND: begin
                        if (tx_done) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    uart_tx_sequencer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (tx_start_q),
        .byte0_i     (tx_byte0_q),
        .byte1_i     (tx_byte1_q),
        .count_i     (tx_count_q),
        .tx_busy_i   (bus.tx_busy),
        .tx_p_data_o (bus.tx_p_data),
        .tx_d_vld_o  (bus.tx_d_vld),
        .done_o      (tx_done)
    );

    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_rd_en    = rf_rd_en_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_fun     = alu_fun_q;
    assign bus.clk_gate_en = clk_gate_en_q;
    assign bus.cmd_err     = cmd_err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level expectation model, RF/ALU/UART-TX
// responders, and one negedge compare process for all strobes.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
    localparam int RSP_TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  env_rf[16];    // register file as written by the DUT
    logic [7:0]  model_rf[16];  // register file as implied by completed frames
    logic [15:0] alu_fixed = 16'hABCD;
    logic [3:0]  rd_addr;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, cyc_rd = 0, cyc_err = 0;
    bit tx_in_flight = 0, rf_silent = 0, alu_silent = 0, alu_late_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input ev_kind_e k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    function automatic logic [31:0] outputs_vec();
        return 32'({bus.rf_addr, bus.rf_wr_en, bus.rf_rd_en, bus.rf_wr_data, bus.alu_en,
                    bus.alu_fun, bus.clk_gate_en, bus.tx_p_data, bus.tx_d_vld, bus.cmd_err});
    endfunction

    // ALU behaviour assumed by the model: function 1 adds the operands,
    // anything else returns the fixed pattern.
    function automatic logic [15:0] alu_model(input logic [3:0] f);
        return (f == 4'd1) ? 16'(model_rf[0]) + 16'(model_rf[1]) : alu_fixed;
    endfunction

    task automatic observe(input ev_t got);
        ev_t want;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got %h required none", got);
        end else begin
            want = exp_q.pop_front();
            check("event", 32'(got), 32'(want));
        end
    endtask

    // Compare process: every strobe must match the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                check("rd_wr_exclusive", 32'(bus.rf_wr_en & bus.rf_rd_en), 32'd0);
                check("alu_en_needs_gate", 32'(bus.alu_en & ~bus.clk_gate_en), 32'd0);
                if (bus.rf_wr_en) observe(mk(EV_WR, bus.rf_addr, bus.rf_wr_data));
                if (bus.rf_rd_en) begin
                    cyc_rd = cyc;
                    observe(mk(EV_RD, bus.rf_addr, 8'h00));
                end
                if (bus.tx_d_vld) begin
                    check("tx_after_busy_toggle", 32'(tx_in_flight), 32'd0);
                    tx_in_flight = 1;
                    tx_log.push_back(bus.tx_p_data);
                    observe(mk(EV_TX, 4'h0, bus.tx_p_data));
                end
                if (bus.cmd_err) begin
                    cyc_err = cyc;
                    observe(mk(EV_ERR, 4'h0, 8'h00));
                end
            end
        end
    end

    // Register file: absorbs writes, answers reads three cycles later.
    initial begin
        bus.rf_rd_data     = '0;
        bus.rf_rd_data_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rf_wr_en === 1'b1) env_rf[bus.rf_addr] = bus.rf_wr_data;
            if (bus.rf_rd_en === 1'b1 && !rf_silent) begin
                rd_addr = bus.rf_addr;
                repeat (3) @(posedge clk);
                #1 bus.rf_rd_data = env_rf[rd_addr];
                bus.rf_rd_data_vld = 1'b1;
                @(posedge clk);
                #1 bus.rf_rd_data_vld = 1'b0;
            end
        end
    end

    // ALU: answers four cycles after alu_en rises, or a stray pulse on request.
    initial begin
        bus.alu_out     = '0;
        bus.alu_out_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_late_req) begin
                @(posedge clk);
                #1 bus.alu_out = 16'h5555;
                bus.alu_out_vld = 1'b1;
                @(posedge clk);
                #1 bus.alu_out_vld = 1'b0;
                alu_late_req = 0;
            end else if (bus.alu_en === 1'b1 && !alu_silent) begin
                repeat (4) @(posedge clk);
                #1 bus.alu_out = (bus.alu_fun == 4'd1) ? 16'(env_rf[0]) + 16'(env_rf[1]) : alu_fixed;
                bus.alu_out_vld = 1'b1;
                @(negedge clk);
                check("gate_on_at_vld", 32'({bus.clk_gate_en, bus.alu_en}), 32'd3);
                @(posedge clk);
                #1 bus.alu_out_vld = 1'b0;
                @(negedge clk);
                check("gate_off_after_vld", 32'({bus.clk_gate_en, bus.alu_en}), 32'd0);
            end
        end
    end

    // UART TX: busy for three cycles after each request.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_d_vld === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
                tx_in_flight = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par = 1'b0, input logic stp = 1'b0);
        bus.rx_p_data  = b;
        bus.rx_d_vld   = 1'b1;
        bus.rx_par_err = par;
        bus.rx_stp_err = stp;
        @(posedge clk);
        #1;
        bus.rx_d_vld   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
        idle(2);
    endtask

    task automatic drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic frame_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(mk(EV_WR, a[3:0], d));
        model_rf[a[3:0]] = d;
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        idle(5);
        drained("drain_wr");
    endtask

    task automatic frame_rd(input logic [7:0] a);
        exp_q.push_back(mk(EV_RD, a[3:0], 8'h00));
        exp_q.push_back(mk(EV_TX, 4'h0, model_rf[a[3:0]]));
        send_byte(8'hBB);
        send_byte(a);
        idle(30);
        drained("drain_rd");
    endtask

    task automatic frame_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [15:0] r;
        exp_q.push_back(mk(EV_WR, 4'd0, a));
        exp_q.push_back(mk(EV_WR, 4'd1, b));
        model_rf[0] = a;
        model_rf[1] = b;
        r = alu_model(f[3:0]);
        exp_q.push_back(mk(EV_TX, 4'h0, r[7:0]));
        exp_q.push_back(mk(EV_TX, 4'h0, r[15:8]));
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(f);
        idle(40);
        drained("drain_alu");
    endtask

    task automatic frame_nop(input logic [7:0] f);
        logic [15:0] r;
        r = alu_model(f[3:0]);
        exp_q.push_back(mk(EV_TX, 4'h0, r[7:0]));
        exp_q.push_back(mk(EV_TX, 4'h0, r[15:8]));
        send_byte(8'hDD);
        send_byte(f);
        idle(40);
        drained("drain_nop");
    endtask

    // Watchdog: a hung handshake still ends the run with a visible failure.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_p_data  = '0;
        bus.rx_d_vld   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            env_rf[i]   = 8'h00;
            model_rf[i] = 8'h00;
        end
        rst_n = 1'b0;
        idle(3);
        check("reset_outputs", outputs_vec(), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write then read back
        frame_wr(8'h05, 8'h3C);
        check("rf_5_written", 32'(env_rf[5]), 32'h3C);
        frame_rd(8'h05);
        check("rd_tx_byte", 32'(tx_log[tx_log.size()-1]), 32'h3C);

        // ALU with operands: 0x12 + 0x34
        frame_alu(8'h12, 8'h34, 8'h01);
        check("op_a_written", 32'(env_rf[0]), 32'h12);
        check("op_b_written", 32'(env_rf[1]), 32'h34);
        check("alu_fun_latched", 32'(bus.alu_fun), 32'h1);
        check("alu_tx_lo", 32'(tx_log[tx_log.size()-2]), 32'h46);
        check("alu_tx_hi", 32'(tx_log[tx_log.size()-1]), 32'h00);

        // ALU without operands
        frame_nop(8'h02);
        check("nop_tx_lo", 32'(tx_log[tx_log.size()-2]), 32'hCD);
        check("nop_tx_hi", 32'(tx_log[tx_log.size()-1]), 32'hAB);

        // Illegal opcode
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'h77);
        idle(3);
        drained("drain_bad_opcode");

        // Parity error in the write-data byte, then a clean write
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h99, 1'b1, 1'b0);
        idle(3);
        drained("drain_par_abort");
        check("rf_5_untouched", 32'(env_rf[5]), 32'h3C);
        frame_wr(8'h06, 8'h11);

        // Stop-bit error in operand A
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hCC);
        send_byte(8'h99, 1'b0, 1'b1);
        idle(3);
        drained("drain_stp_abort");
        check("op_a_untouched", 32'(env_rf[0]), 32'h12);

        // Address bits above ADDR_WIDTH are ignored
        frame_wr(8'hF7, 8'h5A);
        frame_rd(8'h97);
        check("trunc_tx_byte", 32'(tx_log[tx_log.size()-1]), 32'h5A);

        // Read timeout, with a byte dropped during RD_WAIT
        rf_silent = 1;
        exp_q.push_back(mk(EV_RD, 4'd3, 8'h00));
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h03);
        send_byte(8'hAA);
        idle(300);
        drained("drain_timeout");
        check("timeout_latency", 32'(cyc_err - cyc_rd), 32'd255);
        rf_silent = 0;
        frame_rd(8'h05);

        // Reset while waiting on the ALU; a late result must be ignored
        alu_silent = 1;
        send_byte(8'hDD);
        send_byte(8'h03);
        check("alu_wait_outputs", 32'({bus.clk_gate_en, bus.alu_en, bus.alu_fun}), 32'h33);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("reset_mid_alu", outputs_vec(), 32'd0);
        alu_late_req = 1;
        idle(12);
        check("late_vld_ignored", outputs_vec(), 32'd0);
        drained("drain_reset");
        alu_silent = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
